ibex_wb_stage_mo: RTL and testbench

IBEX_WB_STAGE_MO -- requirements
Module: ibex_wb_stage_mo

---
 rtl/ibex_wb_stage_mo.sv | 220 ++++++++++++++++++++++
 tb/tb_ibex_wb_stage_mo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_stage_mo.sv
// Writeback stage with a single-entry stage register for ALU-style results
// and an in-order queue tracking outstanding LSU operations. Load responses
// write the register file directly from the queue head; the stage register
// yields its write port to a load that targets the same register file.
module ibex_wb_stage_mo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RegAddrW  = 5,
  parameter int unsigned LsuDepth  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_wb_i,
  input  logic [1:0]                    instr_type_wb_i,
  input  logic                          rf_fp_id_i,
  input  logic                          rf_we_id_i,
  input  logic [RegAddrW-1:0]           rf_waddr_id_i,
  input  logic [DataWidth-1:0]          rf_wdata_id_i,
  input  logic [31:0]                   pc_id_i,
  input  logic                          instr_is_compressed_id_i,
  input  logic                          instr_perf_count_id_i,
  output logic                          ready_wb_o,
  input  logic                          lsu_resp_valid_i,
  input  logic                          lsu_resp_err_i,
  input  logic [DataWidth-1:0]          rf_wdata_lsu_i,
  output logic                          rf_we_int_o,
  output logic [RegAddrW-1:0]           rf_waddr_int_o,
  output logic [DataWidth-1:0]          rf_wdata_int_o,
  output logic                          rf_we_fp_o,
  output logic [RegAddrW-1:0]           rf_waddr_fp_o,
  output logic [DataWidth-1:0]          rf_wdata_fp_o,
  output logic [DataWidth-1:0]          rf_wdata_fwd_wb_o,
  output logic [(1<<RegAddrW)-1:0]      pend_int_o,
  output logic [(1<<RegAddrW)-1:0]      pend_fp_o,
  output logic                          outstanding_load_wb_o,
  output logic                          outstanding_store_wb_o,
  output logic [$clog2(LsuDepth+1)-1:0] lsu_cnt_o,
  output logic                          instr_done_wb_o,
  output logic [31:0]                   pc_wb_o,
  output logic [1:0]                    perf_instr_ret_wb_o,
  output logic [1:0]                    perf_instr_ret_compressed_wb_o
);

  localparam int unsigned CntW = $clog2(LsuDepth + 1);
  localparam int unsigned PtrW = (LsuDepth > 1) ? $clog2(LsuDepth) : 1;

  typedef enum logic [1:0] {
    WB_OTHER = 2'd0,
    WB_LOAD  = 2'd1,
    WB_STORE = 2'd2
  } wb_instr_type_e;

  typedef struct packed {
    logic                load;
    logic                fp;
    logic [RegAddrW-1:0] waddr;
    logic [31:0]         pc;
    logic                compressed;
    logic                count;
  } lsu_entry_t;

  // Stage register
  logic                 wb_valid_q;
  logic                 wb_fp_q;
  logic                 wb_we_q;
  logic [RegAddrW-1:0]  wb_waddr_q;
  logic [DataWidth-1:0] wb_wdata_q;
  logic [31:0]          wb_pc_q;
  logic                 wb_compressed_q;
  logic                 wb_count_q;

  // LSU queue
  lsu_entry_t           lsu_q [LsuDepth];
  logic [LsuDepth-1:0]  slot_valid_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      lsu_cnt_q;

  wb_instr_type_e instr_type;
  lsu_entry_t     head;
  logic is_lsu, accept, push, pop;
  logic stage_active, stage_wr_req, load_wr, conflict, wb_done, stage_wr_go;
  logic load_int_wr, load_fp_wr, stage_int_wr, stage_fp_wr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(LsuDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_type = wb_instr_type_e'(instr_type_wb_i);
  assign is_lsu     = (instr_type == WB_LOAD) || (instr_type == WB_STORE);
  assign head       = lsu_q[rd_ptr_q];

  // Nothing retires or writes while reset is asserted.
  assign stage_active = wb_valid_q & ~rst_i;
  assign pop          = lsu_resp_valid_i & (lsu_cnt_q != '0) & ~rst_i;

  assign load_wr      = pop & head.load & ~lsu_resp_err_i;
  assign stage_wr_req = stage_active & wb_we_q;
  assign conflict     = stage_wr_req & load_wr & (wb_fp_q == head.fp);
  assign wb_done      = stage_active & ~conflict;
  assign stage_wr_go  = stage_wr_req & ~conflict;

  assign ready_wb_o = (~stage_active | wb_done) & ((lsu_cnt_q < CntW'(LsuDepth)) | pop);
  assign accept     = en_wb_i & ready_wb_o;
  assign push       = accept & is_lsu;

  // Each register file port is driven by the load when it targets that file,
  // otherwise by the stage register; the conflict rule keeps them exclusive.
  assign load_int_wr  = load_wr & ~head.fp;
  assign load_fp_wr   = load_wr & head.fp;
  assign stage_int_wr = stage_wr_go & ~wb_fp_q;
  assign stage_fp_wr  = stage_wr_go & wb_fp_q;

  assign rf_we_int_o    = (load_int_wr & (head.waddr != '0)) |
                          (stage_int_wr & (wb_waddr_q != '0));
  assign rf_waddr_int_o = load_int_wr ? head.waddr : wb_waddr_q;
  assign rf_wdata_int_o = load_int_wr ? rf_wdata_lsu_i : wb_wdata_q;

  assign rf_we_fp_o     = load_fp_wr | stage_fp_wr;
  assign rf_waddr_fp_o  = load_fp_wr ? head.waddr : wb_waddr_q;
  assign rf_wdata_fp_o  = load_fp_wr ? rf_wdata_lsu_i : wb_wdata_q;

  assign rf_wdata_fwd_wb_o = wb_wdata_q;
  assign lsu_cnt_o         = lsu_cnt_q;
  assign instr_done_wb_o   = wb_done | pop;
  assign pc_wb_o           = pop ? head.pc : (stage_active ? wb_pc_q : 32'd0);

  assign perf_instr_ret_wb_o =
      {1'b0, wb_done & wb_count_q} + {1'b0, pop & head.count & ~lsu_resp_err_i};
  assign perf_instr_ret_compressed_wb_o =
      {1'b0, wb_done & wb_count_q & wb_compressed_q} +
      {1'b0, pop & head.count & ~lsu_resp_err_i & head.compressed};

  // Pending-write masks and outstanding flags derived from queue and stage.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pend_int_o             = '0;
    pend_fp_o              = '0;
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int i = 0; i < LsuDepth; i++) begin
      if (slot_valid_q[i]) begin
        if (lsu_q[i].load) begin
          outstanding_load_wb_o = 1'b1;
          if (lsu_q[i].fp) pend_fp_o[lsu_q[i].waddr]  = 1'b1;
          else             pend_int_o[lsu_q[i].waddr] = 1'b1;
        end else begin
          outstanding_store_wb_o = 1'b1;
        end
      end
    end
    if (wb_valid_q && wb_we_q) begin
      if (wb_fp_q) pend_fp_o[wb_waddr_q]  = 1'b1;
      else         pend_int_o[wb_waddr_q] = 1'b1;
    end
    pend_int_o[0] = 1'b0;
  end

  // Stage occupancy: filled by an accepted OTHER, emptied once it completes.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is always assigned with non-blocking <=.
    if (rst_i)                 wb_valid_q <= 1'b0;
    else if (accept & ~is_lsu) wb_valid_q <= 1'b1;
    else if (wb_done)          wb_valid_q <= 1'b0;
  end

  // Stage payload, qualified by wb_valid_q.
  always_ff @(posedge clk_i) begin
    // NOTE: datapath and queue storage are not reset; valid bits guard them.
    if (accept && !is_lsu) begin
      wb_fp_q         <= rf_fp_id_i;
      wb_we_q         <= rf_we_id_i;
      wb_waddr_q      <= rf_waddr_id_i;
      wb_wdata_q      <= rf_wdata_id_i;
      wb_pc_q         <= pc_id_i;
      wb_compressed_q <= instr_is_compressed_id_i;
      wb_count_q      <= instr_perf_count_id_i;
    end
  end

  // Queue pointers, slot valids and occupancy count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lsu_cnt_q    <= '0;
      slot_valid_q <= '0;
    end else begin
      // Clear before set: when full, push and pop share one slot.
      if (pop) begin
        rd_ptr_q               <= ptr_inc(rd_ptr_q);
        slot_valid_q[rd_ptr_q] <= 1'b0;
      end
      if (push) begin
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
        slot_valid_q[wr_ptr_q] <= 1'b1;
      end
      if (push && !pop)      lsu_cnt_q <= lsu_cnt_q + 1'b1;
      else if (pop && !push) lsu_cnt_q <= lsu_cnt_q - 1'b1;
    end
  end

  // Queue entry storage.
  always_ff @(posedge clk_i) begin
    if (push) begin
      lsu_q[wr_ptr_q] <= '{load:       (instr_type == WB_LOAD),
                           fp:         rf_fp_id_i,
                           waddr:      rf_waddr_id_i,
                           pc:         pc_id_i,
                           compressed: instr_is_compressed_id_i,
                           count:      instr_perf_count_id_i};
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding is an LSU protocol error.
  resp_without_request: assert property (@(posedge clk_i) disable iff (rst_i)
    !(lsu_resp_valid_i && (lsu_cnt_q == '0)));
`endif

endmodule

// File: tb/tb_ibex_wb_stage_mo.sv
// Self-checking bench for ibex_wb_stage_mo: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_ibex_wb_stage_mo;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam logic [1:0] T_OTHER = 2'd0, T_LOAD = 2'd1, T_STORE = 2'd2;

  logic          clk, rst;
  logic          en, fp_id, we_id, comp_id, cnt_id;
  logic [1:0]    ty;
  logic [AW-1:0] waddr_id;
  logic [DW-1:0] wdata_id;
  logic [31:0]   pc_id;
  logic          ready;
  logic          resp_v, resp_err;
  logic [DW-1:0] lsu_data;
  logic          we_int, we_fp;
  logic [AW-1:0] waddr_int, waddr_fp;
  logic [DW-1:0] wdata_int, wdata_fp, fwd;
  logic [31:0]   pend_int, pend_fp;
  logic          out_ld, out_st;
  logic [1:0]    lsu_cnt;
  logic          done;
  logic [31:0]   pc_wb;
  logic [1:0]    perf, perf_c;

  int n_checks = 0;
  int n_pass   = 0;

  ibex_wb_stage_mo #(.DataWidth(DW), .RegAddrW(AW), .LsuDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .en_wb_i(en), .instr_type_wb_i(ty), .rf_fp_id_i(fp_id), .rf_we_id_i(we_id),
    .rf_waddr_id_i(waddr_id), .rf_wdata_id_i(wdata_id), .pc_id_i(pc_id),
    .instr_is_compressed_id_i(comp_id), .instr_perf_count_id_i(cnt_id),
    .ready_wb_o(ready),
    .lsu_resp_valid_i(resp_v), .lsu_resp_err_i(resp_err), .rf_wdata_lsu_i(lsu_data),
    .rf_we_int_o(we_int), .rf_waddr_int_o(waddr_int), .rf_wdata_int_o(wdata_int),
    .rf_we_fp_o(we_fp), .rf_waddr_fp_o(waddr_fp), .rf_wdata_fp_o(wdata_fp),
    .rf_wdata_fwd_wb_o(fwd), .pend_int_o(pend_int), .pend_fp_o(pend_fp),
    .outstanding_load_wb_o(out_ld), .outstanding_store_wb_o(out_st),
    .lsu_cnt_o(lsu_cnt), .instr_done_wb_o(done), .pc_wb_o(pc_wb),
    .perf_instr_ret_wb_o(perf), .perf_instr_ret_compressed_wb_o(perf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    bit        load;
    bit        fp;
    bit [4:0]  waddr;
    bit [31:0] pc;
    bit        comp;
    bit        cnt;
  } ent_t;
  ent_t      mq[$];
  bit        sv, s_fp, s_we, s_comp, s_cnt;
  bit [4:0]  s_addr;
  bit [31:0] s_data, s_pc;

  task automatic idle();
    en = 0; ty = T_OTHER; fp_id = 0; we_id = 0; waddr_id = '0; wdata_id = '0;
    pc_id = '0; comp_id = 0; cnt_id = 0; resp_v = 0; resp_err = 0; lsu_data = '0;
  endtask

  task automatic issue(input logic [1:0] t, input bit f, input bit w, input bit [4:0] a,
                       input bit [31:0] d, input bit [31:0] pc, input bit c);
    en = 1; ty = t; fp_id = f; we_id = w; waddr_id = a; wdata_id = d;
    pc_id = pc; comp_id = c; cnt_id = 1;
  endtask

  task automatic respond(input bit err, input bit [31:0] d);
    resp_v = 1; resp_err = err; lsu_data = d;
  endtask

  // Move to the next drive point: just after the falling edge.
  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    n_checks++;
    if (we_int !== 0 || we_fp !== 0 || pend_int !== 0 || pend_fp !== 0 ||
        lsu_cnt !== 0 || done !== 0 || pc_wb !== 0 || perf !== 0 || perf_c !== 0 ||
        out_ld !== 0 || out_st !== 0 || ready !== 1)
      $display("FAIL reset_state: we_int=%0b we_fp=%0b pend_int=%h pend_fp=%h cnt=%0d done=%0b pc=%h perf=%0d ready=%0b, want all 0 and ready=1",
               we_int, we_fp, pend_int, pend_fp, lsu_cnt, done, pc_wb, perf, ready);
    else n_pass++;
  endtask

  task automatic test_other_write();
    step(); issue(T_OTHER, 0, 1, 5'd5, 32'hA5, 32'h100, 0);
    #1;
    n_checks++;
    if (ready !== 1) $display("FAIL other_accept: ready=%0b want 1", ready);
    else n_pass++;
    step(); #1;
    n_checks++;
    if (we_int !== 1 || waddr_int !== 5'd5 || wdata_int !== 32'hA5 || perf !== 2'd1 ||
        done !== 1 || pc_wb !== 32'h100 || we_fp !== 0 || pend_int[5] !== 1)
      $display("FAIL other_write: we=%0b addr=%0d data=%h perf=%0d done=%0b pc=%h pend5=%0b, want 1/5/a5/1/1/100/1",
               we_int, waddr_int, wdata_int, perf, done, pc_wb, pend_int[5]);
    else n_pass++;
    step(); #1;
    n_checks++;
    if (we_int !== 0 || done !== 0) $display("FAIL other_drained: we=%0b done=%0b want 0/0", we_int, done);
    else n_pass++;
  endtask

  task automatic test_load_queue();
    step(); issue(T_LOAD, 1, 1, 5'd3, 32'h0, 32'h200, 0);
    step(); issue(T_LOAD, 0, 1, 5'd7, 32'h0, 32'h204, 0);
    #1;
    n_checks++;
    if (ready !== 1 || lsu_cnt !== 2'd1) $display("FAIL load_second_accept: ready=%0b cnt=%0d want 1/1", ready, lsu_cnt);
    else n_pass++;
    step(); #1;
    n_checks++;
    if (lsu_cnt !== 2'd2 || ready !== 0 || pend_fp[3] !== 1 || pend_int[7] !== 1 || out_ld !== 1 || out_st !== 0)
      $display("FAIL load_full: cnt=%0d ready=%0b pf3=%0b pi7=%0b ld=%0b st=%0b want 2/0/1/1/1/0",
               lsu_cnt, ready, pend_fp[3], pend_int[7], out_ld, out_st);
    else n_pass++;
    step(); respond(0, 32'h11); #1;
    n_checks++;
    if (we_fp !== 1 || waddr_fp !== 5'd3 || wdata_fp !== 32'h11 || we_int !== 0 || ready !== 1 ||
        pc_wb !== 32'h200 || done !== 1)
      $display("FAIL load_resp_fp: we_fp=%0b addr=%0d data=%h we_int=%0b ready=%0b pc=%h done=%0b want 1/3/11/0/1/200/1",
               we_fp, waddr_fp, wdata_fp, we_int, ready, pc_wb, done);
    else n_pass++;
    step(); respond(0, 32'h22); #1;
    n_checks++;
    if (lsu_cnt !== 2'd1 || we_int !== 1 || waddr_int !== 5'd7 || wdata_int !== 32'h22 || pend_fp[3] !== 0)
      $display("FAIL load_resp_int: cnt=%0d we=%0b addr=%0d data=%h pf3=%0b want 1/1/7/22/0",
               lsu_cnt, we_int, waddr_int, wdata_int, pend_fp[3]);
    else n_pass++;
    step(); #1;
    n_checks++;
    if (lsu_cnt !== 0 || out_ld !== 0 || pend_int !== 0) $display("FAIL load_empty: cnt=%0d ld=%0b pend=%h want 0", lsu_cnt, out_ld, pend_int);
    else n_pass++;
  endtask

  task automatic test_conflict();
    step(); issue(T_LOAD, 0, 1, 5'd9, 32'h0, 32'h300, 0);
    step(); issue(T_OTHER, 0, 1, 5'd4, 32'h44, 32'h304, 0);
    step(); respond(0, 32'h99); #1;
    n_checks++;
    if (we_int !== 1 || waddr_int !== 5'd9 || wdata_int !== 32'h99 || ready !== 0 || done !== 1 || perf !== 2'd1)
      $display("FAIL conflict_load_wins: we=%0b addr=%0d data=%h ready=%0b done=%0b perf=%0d want 1/9/99/0/1/1",
               we_int, waddr_int, wdata_int, ready, done, perf);
    else n_pass++;
    step(); #1;
    n_checks++;
    if (we_int !== 1 || waddr_int !== 5'd4 || wdata_int !== 32'h44 || perf !== 2'd1 || pc_wb !== 32'h304)
      $display("FAIL conflict_retry: we=%0b addr=%0d data=%h perf=%0d pc=%h want 1/4/44/1/304",
               we_int, waddr_int, wdata_int, perf, pc_wb);
    else n_pass++;
    step();
  endtask

  task automatic test_dual_port();
    step(); issue(T_LOAD, 1, 1, 5'd2, 32'h0, 32'h400, 1);
    step(); issue(T_OTHER, 0, 1, 5'd6, 32'h66, 32'h402, 1);
    step(); respond(0, 32'h77); #1;
    n_checks++;
    if (we_int !== 1 || waddr_int !== 5'd6 || wdata_int !== 32'h66 || we_fp !== 1 || waddr_fp !== 5'd2 ||
        wdata_fp !== 32'h77 || perf !== 2'd2 || perf_c !== 2'd2 || fwd !== 32'h66)
      $display("FAIL dual_port: int=%0b/%0d/%h fp=%0b/%0d/%h perf=%0d perf_c=%0d fwd=%h want 1/6/66 1/2/77 2 2 66",
               we_int, waddr_int, wdata_int, we_fp, waddr_fp, wdata_fp, perf, perf_c, fwd);
    else n_pass++;
    step();
  endtask

  task automatic test_load_error();
    step(); issue(T_LOAD, 0, 1, 5'd8, 32'h0, 32'h500, 0);
    step(); respond(1, 32'hBAD); #1;
    n_checks++;
    if (we_int !== 0 || we_fp !== 0 || done !== 1 || perf !== 0)
      $display("FAIL load_error: we_int=%0b we_fp=%0b done=%0b perf=%0d want 0/0/1/0", we_int, we_fp, done, perf);
    else n_pass++;
    step(); #1;
    n_checks++;
    if (lsu_cnt !== 0) $display("FAIL load_error_pop: cnt=%0d want 0", lsu_cnt);
    else n_pass++;
  endtask

  task automatic test_x0_and_reset();
    step(); issue(T_OTHER, 0, 1, 5'd0, 32'h55, 32'h600, 0);
    step(); #1;
    n_checks++;
    if (we_int !== 0 || done !== 1 || pend_int[0] !== 0)
      $display("FAIL x0_suppressed: we=%0b done=%0b pend0=%0b want 0/1/0", we_int, done, pend_int[0]);
    else n_pass++;
    step(); issue(T_LOAD, 0, 1, 5'd10, 32'h0, 32'h700, 0);
    step(); issue(T_LOAD, 1, 1, 5'd0, 32'h0, 32'h704, 0);
    step(); rst = 1; respond(0, 32'hEE); #1;
    n_checks++;
    if (lsu_cnt !== 2'd2 || pend_int[10] !== 1 || pend_fp[0] !== 1 || we_int !== 0 || we_fp !== 0)
      $display("FAIL reset_pending: cnt=%0d pi10=%0b pf0=%0b we_int=%0b we_fp=%0b want 2/1/1/0/0",
               lsu_cnt, pend_int[10], pend_fp[0], we_int, we_fp);
    else n_pass++;
    step(); rst = 0; #1;
    n_checks++;
    if (lsu_cnt !== 0 || pend_int !== 0 || pend_fp !== 0 || out_ld !== 0 || ready !== 1 || we_int !== 0 || we_fp !== 0)
      $display("FAIL reset_discard: cnt=%0d pi=%h pf=%h ld=%0b ready=%0b want 0/0/0/0/1",
               lsu_cnt, pend_int, pend_fp, out_ld, ready);
    else n_pass++;
  endtask

  task automatic test_random();
    bit        pop, load_wr, stage_wr, conflict, wb_done, rdy, e_wi, e_wf;
    bit [4:0]  e_ai, e_af;
    bit [31:0] e_di, e_df, e_pc, e_pi, e_pf;
    bit [1:0]  e_perf, e_perfc, e_cnt;
    bit        e_ld, e_st;
    ent_t      h, n;
    mq.delete(); sv = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      en = 1'($urandom_range(0, 1)); ty = 2'($urandom_range(0, 2));
      fp_id = 1'($urandom_range(0, 1)); we_id = 1'($urandom_range(0, 3) != 0);
      waddr_id = 5'($urandom_range(0, 31)); wdata_id = $urandom; pc_id = $urandom;
      comp_id = 1'($urandom_range(0, 1)); cnt_id = 1'($urandom_range(0, 3) != 0);
      resp_v = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      resp_err = ($urandom_range(0, 5) == 0); lsu_data = $urandom;
      #1;
      // Expected behaviour from the model
      h = '{default: 0};
      if (mq.size() > 0) h = mq[0];
      pop      = resp_v && (mq.size() > 0);
      load_wr  = pop && h.load && !resp_err;
      stage_wr = sv && s_we;
      conflict = stage_wr && load_wr && (s_fp == h.fp);
      wb_done  = sv && !conflict;
      rdy      = (!sv || wb_done) && (mq.size() < DEPTH || pop);
      e_wi = 0; e_ai = 0; e_di = 0; e_wf = 0; e_af = 0; e_df = 0;
      if (load_wr && !h.fp) begin
        if (h.waddr != 0) begin e_wi = 1; e_ai = h.waddr; e_di = lsu_data; end
      end else if (stage_wr && !conflict && !s_fp && s_addr != 0) begin
        e_wi = 1; e_ai = s_addr; e_di = s_data;
      end
      if (load_wr && h.fp) begin
        e_wf = 1; e_af = h.waddr; e_df = lsu_data;
      end else if (stage_wr && !conflict && s_fp) begin
        e_wf = 1; e_af = s_addr; e_df = s_data;
      end
      e_perf  = 2'(wb_done && s_cnt) + 2'(pop && h.cnt && !resp_err);
      e_perfc = 2'(wb_done && s_cnt && s_comp) + 2'(pop && h.cnt && !resp_err && h.comp);
      e_pc    = pop ? h.pc : (sv ? s_pc : 32'd0);
      e_pi = 0; e_pf = 0; e_ld = 0; e_st = 0;
      foreach (mq[i]) begin
        if (mq[i].load) begin
          e_ld = 1;
          if (mq[i].fp) e_pf[mq[i].waddr] = 1; else e_pi[mq[i].waddr] = 1;
        end else e_st = 1;
      end
      if (sv && s_we) begin
        if (s_fp) e_pf[s_addr] = 1; else e_pi[s_addr] = 1;
      end
      e_pi[0] = 0;
      e_cnt = 2'(mq.size());

      n_checks++;
      if (ready !== rdy || done !== (wb_done || pop) || lsu_cnt !== e_cnt)
        $display("FAIL rnd_ctrl cyc=%0d: ready=%0b done=%0b cnt=%0d want %0b/%0b/%0d", cyc, ready, done, lsu_cnt, rdy, wb_done || pop, e_cnt);
      else n_pass++;
      n_checks++;
      if (we_int !== e_wi || (e_wi && (waddr_int !== e_ai || wdata_int !== e_di)))
        $display("FAIL rnd_int_port cyc=%0d: %0b/%0d/%h want %0b/%0d/%h", cyc, we_int, waddr_int, wdata_int, e_wi, e_ai, e_di);
      else n_pass++;
      n_checks++;
      if (we_fp !== e_wf || (e_wf && (waddr_fp !== e_af || wdata_fp !== e_df)))
        $display("FAIL rnd_fp_port cyc=%0d: %0b/%0d/%h want %0b/%0d/%h", cyc, we_fp, waddr_fp, wdata_fp, e_wf, e_af, e_df);
      else n_pass++;
      n_checks++;
      if (perf !== e_perf || perf_c !== e_perfc || pc_wb !== e_pc)
        $display("FAIL rnd_retire cyc=%0d: perf=%0d perf_c=%0d pc=%h want %0d/%0d/%h", cyc, perf, perf_c, pc_wb, e_perf, e_perfc, e_pc);
      else n_pass++;
      n_checks++;
      if (pend_int !== e_pi || pend_fp !== e_pf || out_ld !== e_ld || out_st !== e_st)
        $display("FAIL rnd_pending cyc=%0d: pi=%h pf=%h ld=%0b st=%0b want %h/%h/%0b/%0b", cyc, pend_int, pend_fp, out_ld, out_st, e_pi, e_pf, e_ld, e_st);
      else n_pass++;
      if (sv) begin
        n_checks++;
        if (fwd !== s_data) $display("FAIL rnd_fwd cyc=%0d: fwd=%h want %h", cyc, fwd, s_data);
        else n_pass++;
      end

      // Advance the model to the state after the coming rising edge
      if (pop) void'(mq.pop_front());
      if (en && rdy && (ty == T_LOAD || ty == T_STORE)) begin
        n = '{load: (ty == T_LOAD), fp: fp_id, waddr: waddr_id, pc: pc_id, comp: comp_id, cnt: cnt_id};
        mq.push_back(n);
      end
      if (en && rdy && ty == T_OTHER) begin
        sv = 1; s_fp = fp_id; s_we = we_id; s_addr = waddr_id; s_data = wdata_id;
        s_pc = pc_id; s_comp = comp_id; s_cnt = cnt_id;
      end else if (wb_done) begin
        sv = 0;
      end
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_other_write();
    test_load_queue();
    test_conflict();
    test_dual_port();
    test_load_error();
    test_x0_and_reset();
    test_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
